// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Drain stage for the 8-bit byte FIFO (fifo_tek). When the FIFO reports data,
// the block issues one read strobe, captures the returned byte, and shifts it
// out on an asynchronous-serial line as start bit, 8 data bits LSB first, and
// one stop bit. Each bit is held for CLKS_PER_BIT clock cycles.
//
// Optional build macro: TX_PARITY_EN
//   Defined   - an even-parity bit is sent between the last data bit and the
//               stop bit (11 bit times per frame).
//   Undefined - no parity bit (10 bit times per frame).
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//   DATA_W        byte width, must match the FIFO (8)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   fifo_empty  upstream FIFO holds no data
//   fifo_data   FIFO read data, valid the cycle after enable_rd is sampled
//   enable_rd   one-cycle FIFO read strobe per byte (registered)
//   tx          serial output, idles high (registered)
//   busy        high from the read request to the end of the stop bit
//   tx_done     one-cycle pulse in the last cycle of the stop bit
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              enable_rd,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int               IDX_W    = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  // With one cycle per bit, the first stop cycle is also the last one.
  localparam logic             DONE_ON_ENTRY = (CLKS_PER_BIT == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;      // cycles spent in the current bit
  logic [IDX_W-1:0]  bit_idx;  // data bit currently on the line
  logic [DATA_W-1:0] shreg;    // byte being sent, LSB on the line
`ifdef TX_PARITY_EN
  logic              par;      // even parity of the captured byte
`endif

  // NOTE: every register here, outputs included, is written with non-blocking
  // assignments in one clocked block, so each output is a flop and the block
  // cannot infer a latch or create ordering races between state and outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
`ifdef TX_PARITY_EN
      par       <= 1'b0;
`endif
      enable_rd <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!fifo_empty) begin
            state     <= S_RD;
            enable_rd <= 1'b1;
            busy      <= 1'b1;
          end
        end

        S_RD: begin
          enable_rd <= 1'b0;
          state     <= S_WAIT;
        end

        // FIFO data is valid during this cycle; capture it and start the frame.
        S_WAIT: begin
          shreg <= fifo_data;
`ifdef TX_PARITY_EN
          par   <= ^fifo_data;
`endif
          cnt   <= '0;
          tx    <= 1'b0;
          state <= S_START;
        end

        S_START: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            tx    <= shreg[0];
            state <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            shreg <= shreg >> 1;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
`ifdef TX_PARITY_EN
              tx      <= par;
              state   <= S_PARITY;
`else
              tx      <= 1'b1;
              tx_done <= DONE_ON_ENTRY;
              state   <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 1'b1;
              // shreg[1] is the bit that lands in shreg[0] on this edge.
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef TX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            tx      <= 1'b1;
            tx_done <= DONE_ON_ENTRY;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            tx_done <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end else begin
            cnt     <= cnt + 1'b1;
            // Raise the pulse so it is visible exactly in the final stop cycle.
            tx_done <= (cnt == CNT_LAST - 1'b1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Self-checking bench for fifo_uart_tx. A queue-based FIFO model feeds the DUT;
// every byte expected on the line is pushed into a scoreboard queue when it is
// written to the FIFO. An independent monitor captures each serial frame,
// compares it with the ideal waveform built from the byte, and checks the
// tx_done pulse, busy, read-to-start latency and inter-frame gap.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk        = 1'b0;
  logic       rst        = 1'b0;
  logic       fifo_empty = 1'b0;  // the FIFO starts preloaded with one byte
  logic [7:0] fifo_data  = 8'h00;
  logic       enable_rd;
  logic       tx;
  logic       busy;
  logic       tx_done;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .enable_rd (enable_rd),
    .tx        (tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  int         n_cmp    = 0;
  int         n_bad    = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         cyc      = 0;
  int         rd_cyc   = -100;
  int         rd_count = 0;
  int         pushes   = 0;
  int         prev_end = -100;
  bit         gap_exp  = 1'b0;
  bit         glitch   = 1'b0;
  bit         mon_en   = 1'b1;
  bit         chk_gap  = 1'b0;
  logic       prev_rd  = 1'b0;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit expect_frame);
    fifo_q.push_back(b);
    pushes++;
    if (expect_frame) exp_q.push_back(b);
  endtask

  // FIFO model: a read strobe sampled at an edge returns data shortly after
  // that edge. While idle, data_out wanders to prove the DUT ignores it.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (enable_rd === 1'b1) begin
        rd_cyc = cyc;
        rd_count++;
        check("read_not_empty", fifo_q.size() > 0, 1'b1);
        check("rd_pulse_width", prev_rd, 1'b0);
        prev_rd = 1'b1;
        #1;
        if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      end else begin
        prev_rd = 1'b0;
        #1;
        fifo_data = 8'($urandom);
      end
      fifo_empty = (fifo_q.size() == 0) ? !glitch : 1'b0;
    end
  end

  // Capture one frame starting at the current negedge (first start-bit cycle).
  task automatic check_frame();
    logic [7:0]       b;
    logic [7:0]       got;
    logic [NBITS-1:0] bits;
    logic [FLEN-1:0]  s_tx, s_done, s_busy, done_exp;
    int               start, bad_tx;
    start = cyc;
    for (int i = 0; i < FLEN; i++) begin
      if (i > 0) @(negedge clk);
      s_tx[i]   = tx;
      s_done[i] = tx_done;
      s_busy[i] = busy;
    end
    check("frame_has_expected_byte", exp_q.size() > 0, 1'b1);
    if (exp_q.size() == 0) return;
    b = exp_q.pop_front();
`ifdef TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
    check("parity_bit", s_tx[9*CPB + CPB/2], ^b);
`else
    bits = {1'b1, b, 1'b0};
`endif
    bad_tx = 0;
    for (int i = 0; i < FLEN; i++)
      if (s_tx[i] !== bits[i / CPB]) bad_tx++;
    for (int k = 0; k < 8; k++) got[k] = s_tx[(k+1)*CPB + CPB/2];
    done_exp = '0;
    done_exp[FLEN-1] = 1'b1;
    check("frame_byte", got, b);
    check("frame_wave_bad_cycles", bad_tx, 0);
    check("frame_tx_done", s_done, done_exp);
    check("frame_busy", s_busy, {FLEN{1'b1}});
    check("read_to_start_latency", start - rd_cyc, 1);
    if (gap_exp) check("inter_frame_gap", start - prev_end, 4);
    prev_end = cyc;
    gap_exp  = chk_gap && (fifo_q.size() > 0);
    @(negedge clk);
    check("after_frame_tx_busy_done", {tx, busy, tx_done}, 3'b100);
  endtask

  // Monitor: a low line while idle marks the first start-bit cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && rst && tx === 1'b0) check_frame();
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || fifo_q.size() > 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_in_time", n < budget, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_tx_low(input int budget);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_seen", n < budget, 1'b1);
  endtask

  initial begin
    int bad_idle;
    int rd_before;

    // Reset hold with data waiting: nothing may move until release.
    push(8'h08, 1'b1);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold_outputs", {tx, enable_rd, busy, tx_done}, 4'b1000);
    end
    rst = 1'b1;
    @(negedge clk);
    check("read_after_release", enable_rd, 1'b1);
    wait_drain(500);

    // Back-to-back frames: minimum gap, one read per byte.
    chk_gap = 1'b1;
    push(8'h08, 1'b1);
    push(8'h09, 1'b1);
    push(8'h0A, 1'b1);
    push(8'h0C, 1'b1);
    wait_drain(2000);
    chk_gap = 1'b0;
    check("b2b_read_count", rd_count, pushes);

    // fifo_empty toggles during the data bits: frame unchanged, no extra read.
    push(8'h0C, 1'b1);
    wait_tx_low(100);
    repeat (CPB + 1) @(negedge clk);
    for (int i = 0; i < 6 * CPB; i++) begin
      glitch = ~glitch;
      @(negedge clk);
    end
    glitch = 1'b0;
    wait_drain(500);
    check("glitch_read_count", rd_count, pushes);

    // Reset in the middle of data bit 3: byte is dropped, line returns high.
    mon_en = 1'b0;
    push(8'h0A, 1'b0);
    wait_tx_low(100);
    repeat (4 * CPB + 1) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_midframe_outputs", {tx, busy, tx_done, enable_rd}, 4'b1000);
    rst = 1'b1;
    rd_before = rd_count;
    bad_idle = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad_idle++;
    end
    check("idle_after_reset_bad_cycles", bad_idle, 0);
    check("no_read_after_reset_when_empty", rd_count, rd_before);
    mon_en = 1'b1;

    // Fresh byte after reset starts a normal frame.
    push(8'h5A, 1'b1);
    wait_drain(500);

    // Random bytes with random spacing, occasionally two at once.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 50)) @(negedge clk);
      push(8'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) push(8'($urandom), 1'b1);
    end
    wait_drain(30 * (FLEN + 10));
    check("total_read_count", rd_count, pushes);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the 8-bit byte FIFO (fifo_tek). It pulls one byte at a time using the FIFO's read-enable pulse and serialises each byte onto a single asynchronous-serial line: start bit, 8 data bits LSB first, stop bit. This is the drain stage that empties the FIFO toward an off-chip link.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; integer >= 1; bit counter width is $clog2(CLKS_PER_BIT)+1.
DATA_W, 8, byte width; must match the FIFO data width; fixed at 8 for this revision.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-low; sampled on the rising edge of clk.
fifo_empty  input  1  high when the upstream FIFO holds no data.
fifo_data  input  8  FIFO data_out; valid the cycle after the FIFO samples enable_rd high.
enable_rd  output  1  FIFO read strobe; registered; high for exactly one cycle per byte.
tx  output  1  serial line; registered; idle level 1.
busy  output  1  high from the read request until the end of the stop bit.
tx_done  output  1  one-cycle pulse during the last cycle of the stop bit.

Behaviour:
- Reset (rst==0 at an edge): tx=1, enable_rd=0, busy=0, tx_done=0, state=IDLE, counters=0, shift register=0. Reset overrides everything, including mid-frame. The in-flight byte is lost and tx returns to 1 on that edge.
- States: IDLE -> RD -> WAIT -> START -> DATA -> STOP -> IDLE.
- IDLE: tx=1, busy=0. If fifo_empty==0 at an edge, go to RD.
- RD: one cycle. enable_rd=1, busy=1.
- WAIT: one cycle. enable_rd=0. At the end of WAIT, load fifo_data into the shift register.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, each held CLKS_PER_BIT cycles, LSB first. Shift right after each bit.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_done=1 in the final STOP cycle only. Then go to IDLE.
- Latency: fifo_empty sampled low at edge E -> enable_rd high in cycle E+1 -> tx falls in cycle E+3.
- Frame length: 10*CLKS_PER_BIT cycles of tx activity. Minimum gap between frames is 3 cycles (IDLE, RD, WAIT), so at most one byte is read per frame.
- enable_rd is never asserted while fifo_empty==1 is sampled in IDLE. Exactly one enable_rd pulse occurs per frame.
- fifo_empty and fifo_data changes outside IDLE/WAIT are ignored; the byte is frozen once loaded.
- CLKS_PER_BIT==1 is legal and gives 1 cycle per bit.
- No other outputs change while in IDLE.

Optional Feature:
Macro TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame becomes 11*CLKS_PER_BIT cycles.
- Undefined: no parity state; frame is 10*CLKS_PER_BIT cycles. All other timing is identical.

Test Plan:
- Reset hold: rst=0 for 2 cycles with fifo_empty=0 -> tx=1, enable_rd=0, busy=0, tx_done=0 throughout. No read is issued until 1 edge after rst=1.
- Single byte, CLKS_PER_BIT=4, FIFO preloaded with 8'h08, fifo_empty falls -> exactly one enable_rd pulse; tx falls 3 cycles after the sample; tx shows bits 0 | 0,0,0,1,0,0,0,0 | 1, each 4 cycles wide; tx_done pulses at cycle 40 of the frame; busy=0 afterwards.
- Back-to-back: FIFO holds 8'h08, 8'h09, 8'h0A, 8'h0C -> 4 frames with the LSB-first patterns of each byte; 3-cycle idle gap between stop end and next start; 4 enable_rd pulses total; none after fifo_empty=1.
- Empty mid-frame: fifo_empty toggles 1/0 during DATA of byte 8'h0C -> the frame is unchanged and no extra enable_rd occurs.
- Reset mid-frame: rst=0 during bit 3 of 8'h0A -> tx=1 next edge, busy=0, no tx_done; after release a new frame starts only if fifo_empty==0.
- TX_PARITY_EN defined, byte 8'h08 -> parity bit 1 precedes the stop bit; frame length 44 cycles. Byte 8'h0C -> parity bit 0.
